tick_scheduler: RTL and testbench

Run-control and configuration block for the prescaled event counter. It gates a programmable prescaler and a small up-counter through a four-state controller. It accepts a divide/limit configuration over a valid/ready handshake and emits single-cycle `tick` enables rather than a derived clock. It sits between software-facing control logic and any logic that needs slow, periodic, clock-enable events.

---
 rtl/tick_scheduler_if.sv | 29 ++
 rtl/tick_scheduler.sv | 127 ++++++++++++
 tb/tb_tick_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// Configuration handshake, run-control and tick/status signals of the tick scheduler.
// The master modport is the software-facing side; the slave modport is the scheduler.
interface tick_scheduler_if #(
    parameter int CNT_W   = 26,
    parameter int COUNT_W = 4
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div;
    logic [COUNT_W-1:0] cfg_limit;
    logic               cfg_oneshot;
    logic               start;
    logic               stop;
    logic               hold;
    logic               tick;
    logic [COUNT_W-1:0] upcount;
    logic               busy;
    logic               done;

    modport master (
        output cfg_valid, cfg_div, cfg_limit, cfg_oneshot, start, stop, hold,
        input  cfg_ready, tick, upcount, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_limit, cfg_oneshot, start, stop, hold,
        output cfg_ready, tick, upcount, busy, done
    );
endinterface

// File: rtl/tick_scheduler.sv
// Run-control block: a gated prescaler emits one-cycle tick enables and advances a
// small wrapping or one-shot event counter, sequenced by an IDLE/RUN/HOLD/DONE controller.
module tick_scheduler #(
    parameter int               CNT_W     = 26,
    parameter int               COUNT_W   = 4,
    parameter logic [CNT_W-1:0] DIV_RESET = {CNT_W{1'b1}}
) (
    input logic              clk,
    input logic              reset,
    tick_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_next;
    logic [CNT_W-1:0]   presc_q, presc_next;
    logic [COUNT_W-1:0] upcount_q, upcount_next;
    logic               tick_q, tick_next;
    logic               done_q, done_next;
    logic [CNT_W-1:0]   div_q, div_next;
    logic [COUNT_W-1:0] limit_q, limit_next;
    logic               oneshot_q, oneshot_next;

    logic               cfg_fire;
    logic [COUNT_W-1:0] count_wrap;

    assign cfg_fire   = bus.cfg_valid && (state_q == IDLE);
    assign count_wrap = (upcount_q == limit_q) ? '0 : upcount_q + COUNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Datapath and configuration registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q   <= '0;
            upcount_q <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            div_q     <= DIV_RESET;
            limit_q   <= '1;
            oneshot_q <= 1'b0;
        end else begin
            presc_q   <= presc_next;
            upcount_q <= upcount_next;
            tick_q    <= tick_next;
            done_q    <= done_next;
            div_q     <= div_next;
            limit_q   <= limit_next;
            oneshot_q <= oneshot_next;
        end
    end

    // Next-state logic; within RUN/HOLD stop outranks hold, and hold outranks a tick
    always_comb begin
        state_next   = state_q;
        presc_next   = presc_q;
        upcount_next = upcount_q;
        tick_next    = 1'b0;
        done_next    = 1'b0;
        div_next     = div_q;
        limit_next   = limit_q;
        oneshot_next = oneshot_q;

        if (cfg_fire) begin
            div_next     = bus.cfg_div;
            limit_next   = bus.cfg_limit;
            oneshot_next = bus.cfg_oneshot;
        end

        unique case (state_q)
            IDLE: begin
                presc_next = '0;
                if (bus.start) begin
                    state_next   = RUN;
                    upcount_next = '0;
                end
            end
            RUN, HOLD: begin
                if (bus.stop) begin
                    state_next = IDLE;
                    presc_next = '0;
                end else if (bus.hold) begin
                    state_next = HOLD;
                end else begin
                    state_next = RUN;
                    if (presc_q == div_q) begin
                        presc_next   = '0;
                        tick_next    = 1'b1;
                        upcount_next = count_wrap;
                        if (oneshot_q && (count_wrap == limit_q)) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        presc_next = presc_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                presc_next = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN) || (state_q == HOLD);
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.upcount   = upcount_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler: reset, continuous and one-shot runs,
// hold/stop priority, stalled configuration offers and mid-run reset.
module tb_tick_scheduler;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    tick_scheduler_if #(.CNT_W(26), .COUNT_W(4)) bus ();

    tick_scheduler #(.CNT_W(26), .COUNT_W(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [25:0] d, input logic [3:0] l,
                                 input logic os, input logic st, input logic sp, input logic hd);
        bus.cfg_valid   = v;
        bus.cfg_div     = d;
        bus.cfg_limit   = l;
        bus.cfg_oneshot = os;
        bus.start       = st;
        bus.stop        = sp;
        bus.hold        = hd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset held low for two edges
        reset = 1'b0;
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tickClk();
        tickClk();
        checkOutput("rst_upcount", 32'(bus.upcount), 32'd0);
        checkOutput("rst_tick", 32'(bus.tick), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_ready", 32'(bus.cfg_ready), 32'd1);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        tickClk();
        checkOutput("idle_ready", 32'(bus.cfg_ready), 32'd1);

        // Continuous run, div=3 limit=5, config transferred on the start edge
        $display("[TB] continuous div=3 limit=5");
        applyStimulus(1'b1, 26'd3, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        tickClk();
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("c_busy", 32'(bus.busy), 32'd1);
        checkOutput("c_ready", 32'(bus.cfg_ready), 32'd0);
        checkOutput("c_upcount0", 32'(bus.upcount), 32'd0);
        for (int i = 1; i <= 28; i++) begin
            tickClk();
            checkOutput("c_tick", 32'(bus.tick), (i % 4 == 0) ? 32'd1 : 32'd0);
            checkOutput("c_upcount", 32'(bus.upcount), 32'((i / 4) % 6));
            checkOutput("c_done", 32'(bus.done), 32'd0);
        end
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tickClk();
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("c_stop_busy", 32'(bus.busy), 32'd0);
        checkOutput("c_stop_tick", 32'(bus.tick), 32'd0);
        checkOutput("c_stop_upcount", 32'(bus.upcount), 32'd1);
        checkOutput("c_stop_ready", 32'(bus.cfg_ready), 32'd1);

        // One-shot div=0 limit=3: three back-to-back ticks, done with the third
        $display("[TB] one-shot div=0 limit=3");
        applyStimulus(1'b1, 26'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tickClk();
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("o_upcount0", 32'(bus.upcount), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tickClk();
            checkOutput("o_tick", 32'(bus.tick), 32'd1);
            checkOutput("o_upcount", 32'(bus.upcount), 32'(i));
            checkOutput("o_done", 32'(bus.done), (i == 3) ? 32'd1 : 32'd0);
            checkOutput("o_busy", 32'(bus.busy), (i == 3) ? 32'd0 : 32'd1);
        end
        checkOutput("o_done_ready", 32'(bus.cfg_ready), 32'd0);
        tickClk();
        checkOutput("o_idle_tick", 32'(bus.tick), 32'd0);
        checkOutput("o_idle_done", 32'(bus.done), 32'd0);
        checkOutput("o_idle_ready", 32'(bus.cfg_ready), 32'd1);
        checkOutput("o_idle_upcount", 32'(bus.upcount), 32'd3);

        // div=7 continuous, hold for edges 11..15 pushes the tick from edge 16 to 21
        $display("[TB] hold and stop, div=7");
        applyStimulus(1'b1, 26'd7, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
        tickClk();
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 21; i++) begin
            tickClk();
            applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0,
                          ((i + 1) >= 11) && ((i + 1) <= 15));
            checkOutput("h_tick", 32'(bus.tick), (i == 8 || i == 21) ? 32'd1 : 32'd0);
            checkOutput("h_upcount", 32'(bus.upcount), (i < 8) ? 32'd0 : (i < 21) ? 32'd1 : 32'd2);
            checkOutput("h_busy", 32'(bus.busy), 32'd1);
        end
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tickClk();
        checkOutput("h_hold_busy", 32'(bus.busy), 32'd1);
        checkOutput("h_hold_tick", 32'(bus.tick), 32'd0);
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tickClk();
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("h_stop_busy", 32'(bus.busy), 32'd0);
        checkOutput("h_stop_tick", 32'(bus.tick), 32'd0);
        checkOutput("h_stop_upcount", 32'(bus.upcount), 32'd2);
        checkOutput("h_stop_ready", 32'(bus.cfg_ready), 32'd1);

        // Config offered during a run stalls; old div=7 stays in force
        $display("[TB] config stall during run");
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tickClk();
        applyStimulus(1'b1, 26'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tickClk();
            checkOutput("s_ready", 32'(bus.cfg_ready), 32'd0);
            checkOutput("s_tick", 32'(bus.tick), (i == 8) ? 32'd1 : 32'd0);
            checkOutput("s_upcount", 32'(bus.upcount), (i >= 8) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 26'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        tickClk();
        applyStimulus(1'b1, 26'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("s_stop_ready", 32'(bus.cfg_ready), 32'd1);
        tickClk();
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tickClk();
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tickClk();
            checkOutput("s_new_tick", 32'(bus.tick), (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("s_new_upcount", 32'(bus.upcount), 32'(i / 2));
            checkOutput("s_new_done", 32'(bus.done), (i == 4) ? 32'd1 : 32'd0);
        end
        tickClk();
        checkOutput("s_new_idle", 32'(bus.cfg_ready), 32'd1);

        // Reset pulled low during a one-shot with the prescaler at 2
        $display("[TB] reset mid one-shot");
        applyStimulus(1'b1, 26'd7, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        tickClk();
        applyStimulus(1'b0, 26'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tickClk();
        tickClk();
        checkOutput("r_pre_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        tickClk();
        checkOutput("r_upcount", 32'(bus.upcount), 32'd0);
        checkOutput("r_tick", 32'(bus.tick), 32'd0);
        checkOutput("r_done", 32'(bus.done), 32'd0);
        checkOutput("r_busy", 32'(bus.busy), 32'd0);
        checkOutput("r_ready", 32'(bus.cfg_ready), 32'd1);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tickClk();
            checkOutput("r_after_done", 32'(bus.done), 32'd0);
            checkOutput("r_after_tick", 32'(bus.tick), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
